bsm_operand_serializer: RTL and testbench
=========================================

BSM_OPERAND_SERIALIZER -- requirements
Module: bsm_operand_serializer

Interface
REQ-001 The block SHALL have exactly one clock, clk, and reset rst, which is asynchronous and active-high.
REQ-002 The ports SHALL be as follows, clock and reset first:
- clk  in  1  rising-edge clock
- rst  in  1  async active-high reset
- in_valid  in  1  operand pair offered
- in_ready  out  1  block can accept a pair (IDLE only)
- A_in  in  32  signed operand A, low WA_in bits significant
- B_in  in  32  signed operand B, low WB_in bits significant
- WA_in  in  5  width of A
- WB_in  in  5  width of B
- start  out  1  one-cycle start pulse to the multiplier
- WA  out  5  registered effective width of A, held for the whole operation
- WB  out  5  registered effective width of B, held for the whole operation
- bitAout  out  1  serial A, LSB first
- bitBout  out  1  serial B, LSB first
- bsm_O  in  32  multiplier product
- bsm_done  in  1  multiplier done flag
- res  out  32  captured signed product
- res_valid  out  1  res holds a result
- res_err  out  1  qualifies res_valid: timeout, res=0
- res_ready  in  1  consumer takes result
- busy  out  1  state != IDLE
REQ-003 The block SHALL have one parameter: TIMEOUT, default 8, the number of cycles to wait for bsm_done after the last bit.

Function
REQ-004 The block SHALL implement the states IDLE, START, SHIFT, WAITD and RESULT.
REQ-005 The effective widths SHALL be clamped at accept time: a value of 0 becomes 1, and a value above 16 becomes 16.
REQ-006 Clamping SHALL guarantee that the product fits in 32 bits.
REQ-007 In IDLE, in_ready SHALL be 1. A cycle with in_valid=1 SHALL register A_in, B_in and the clamped WA and WB, then go to START.
REQ-008 In START, the block SHALL assert start=1 for exactly one cycle, clear the bit counter k to 0, then go to SHIFT.
REQ-009 In SHIFT cycle k (k = 0..maxW-1, where maxW = max(WA,WB)), the outputs SHALL be:
- bitAout = A[k] for k < WA, else A[WA-1] (sign extension)
- bitBout = B[k] for k < WB, else B[WB-1] (sign extension)
REQ-010 After the SHIFT cycle with k = maxW-1, the block SHALL go to WAITD and clear the timeout counter.
REQ-011 Outside SHIFT, bitAout and bitBout SHALL be 0.
REQ-012 WA and WB SHALL change only on an IDLE accept and SHALL be stable from START until the return to IDLE.
REQ-013 In WAITD, when bsm_done=1 the block SHALL capture res <= bsm_O, set res_valid=1 and res_err=0, and go to RESULT.
REQ-014 If bsm_done is not seen within TIMEOUT cycles in WAITD, the block SHALL set res=0, res_valid=1 and res_err=1, and go to RESULT.
REQ-015 Any bsm_done pulse outside WAITD SHALL be ignored.
REQ-016 In RESULT, res, res_valid and res_err SHALL hold stable until res_ready=1.
REQ-017 In the RESULT cycle with res_ready=1, the block SHALL clear res_valid and res_err and go to IDLE.
REQ-018 in_ready SHALL be 0 in that RESULT cycle, so a new operand pair is accepted no earlier than the following cycle.
REQ-019 The minimum latency from the accept cycle to res_valid SHALL be 2 + maxW + 1 cycles, assuming bsm_done arrives in the first WAITD cycle.
REQ-020 A new in_valid SHALL never abort an operation in progress, and in_ready SHALL be 0 in every state except IDLE.

Reset
REQ-021 While rst=1, asynchronously, the block SHALL force state=IDLE.
REQ-022 While rst=1, asynchronously, the following SHALL all be 0: start, WA, WB, bitAout, bitBout, res, res_valid, res_err, busy, and all counters.
REQ-023 in_ready SHALL be 1 during reset.
REQ-024 A reset asserted mid-SHIFT or in WAITD SHALL discard the operation, and the block SHALL produce no result afterwards.

Verification
REQ-025 Basic product: A_in=5, WA_in=4, B_in=3, WB_in=3 -> the bench SHALL check:
- start pulses once
- bitAout = 1,0,1,0
- bitBout = 1,1,0,0 (sign-extended 0)
- model multiplier yields res=15, res_err=0
REQ-026 Signed product: A_in=-3 (4'b1101), WA_in=4, B_in=7, WB_in=4 -> the bench SHALL check bitAout=1,0,1,1 and res=-21 (32'hFFFFFFEB).
REQ-027 Clamp: WA_in=0, WB_in=20, A_in=1, B_in=2 -> the bench SHALL check WA=1, WB=16, and 16 SHIFT cycles with bitAout=1 then 1 repeated (sign extension of 1-bit A).
REQ-028 Backpressure: hold res_ready=0 for 10 cycles after res_valid -> the bench SHALL check res stable, in_ready=0, and a second in_valid not accepted until one cycle after res_ready=1.
REQ-029 Timeout: tie bsm_done=0 -> the bench SHALL check res_valid=1 with res_err=1 and res=0 exactly TIMEOUT cycles after entering WAITD.
REQ-030 Reset mid-operation: assert rst during SHIFT k=2 -> the bench SHALL check all outputs 0 immediately, in_ready=1, and no res_valid afterwards.

Source files
------------

// File: rtl/bsm_operand_serializer.sv
// rtl/bsm_operand_serializer.sv - serializes a signed operand pair LSB-first into a bit-serial multiplier and captures its product
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready      operand pair handshake (accepted only in IDLE)
//   A_in, B_in, WA_in, WB_in signed operands and their widths (clamped to 1..16)
//   start                    one-cycle pulse to the multiplier before the first bit
//   WA, WB                   effective widths, held for the whole operation
//   bitAout, bitBout         serial operand bits, LSB first, sign-extended to max(WA,WB)
//   bsm_O, bsm_done          multiplier product and done flag (honoured only while waiting)
//   res, res_valid, res_err  captured product; res_err marks a timeout with res=0
//   res_ready                consumer takes the result
//   busy                     operation in progress
module bsm_operand_serializer #(
    parameter int TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A_in,
    input  logic [31:0] B_in,
    input  logic [4:0]  WA_in,
    input  logic [4:0]  WB_in,
    output logic        start,
    output logic [4:0]  WA,
    output logic [4:0]  WB,
    output logic        bitAout,
    output logic        bitBout,
    input  logic [31:0] bsm_O,
    input  logic        bsm_done,
    output logic [31:0] res,
    output logic        res_valid,
    output logic        res_err,
    input  logic        res_ready,
    output logic        busy
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SHIFT,
        S_WAITD,
        S_RESULT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [4:0]  wa_q, wa_d;
    logic [4:0]  wb_q, wb_d;
    logic [4:0]  k_q, k_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [31:0] res_q, res_d;
    logic        res_valid_q, res_valid_d;
    logic        res_err_q, res_err_d;

    logic [4:0]  max_w;
    logic [4:0]  idx_a, idx_b;

    // Widths are clamped to 16, so operand bits above 15 can never be sent.
    logic unused_hi;
    assign unused_hi = ^{A_in[31:16], B_in[31:16]};

    // 0 -> 1 and >16 -> 16, keeping the 16x16 product inside 32 bits.
    function automatic logic [4:0] clamp_w(input logic [4:0] w);
        if (w == 5'd0) begin
            return 5'd1;
        end else if (w > 5'd16) begin
            return 5'd16;
        end
        return w;
    endfunction

    assign max_w = (wa_q > wb_q) ? wa_q : wb_q;
    // Past its own width an operand keeps repeating its sign bit.
    assign idx_a = (k_q < wa_q) ? k_q : (wa_q - 5'd1);
    assign idx_b = (k_q < wb_q) ? k_q : (wb_q - 5'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            wa_q        <= '0;
            wb_q        <= '0;
            k_q         <= '0;
            tmo_q       <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            wa_q        <= wa_d;
            wb_q        <= wb_d;
            k_q         <= k_d;
            tmo_q       <= tmo_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            res_err_q   <= res_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        wa_d        = wa_q;
        wb_d        = wb_q;
        k_d         = k_q;
        tmo_d       = tmo_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        res_err_d   = res_err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = A_in[15:0];
                    b_d     = B_in[15:0];
                    wa_d    = clamp_w(WA_in);
                    wb_d    = clamp_w(WB_in);
                    state_d = S_START;
                end
            end
            S_START: begin
                k_d     = 5'd0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (k_q == max_w - 5'd1) begin
                    tmo_d   = '0;
                    state_d = S_WAITD;
                end else begin
                    k_d = k_q + 5'd1;
                end
            end
            S_WAITD: begin
                if (bsm_done) begin
                    res_d       = bsm_O;
                    res_valid_d = 1'b1;
                    res_err_d   = 1'b0;
                    state_d     = S_RESULT;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    res_d       = '0;
                    res_valid_d = 1'b1;
                    res_err_d   = 1'b1;
                    state_d     = S_RESULT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    res_err_d   = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready = (state_q == S_IDLE);
        busy     = (state_q != S_IDLE);
        start    = (state_q == S_START);
        bitAout  = 1'b0;
        bitBout  = 1'b0;
        if (state_q == S_SHIFT) begin
            bitAout = a_q[idx_a[3:0]];
            bitBout = b_q[idx_b[3:0]];
        end
    end

    assign WA        = wa_q;
    assign WB        = wb_q;
    assign res       = res_q;
    assign res_valid = res_valid_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_bsm_operand_serializer.sv
// tb/tb_bsm_operand_serializer.sv - directed bench for bsm_operand_serializer with a behavioural serial multiplier
module tb_bsm_operand_serializer;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A_in;
    logic [31:0] B_in;
    logic [4:0]  WA_in;
    logic [4:0]  WB_in;
    logic        start;
    logic [4:0]  WA;
    logic [4:0]  WB;
    logic        bitAout;
    logic        bitBout;
    logic [31:0] bsm_O;
    logic        bsm_done;
    logic [31:0] res;
    logic        res_valid;
    logic        res_err;
    logic        res_ready;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    bsm_operand_serializer #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A_in      (A_in),
        .B_in      (B_in),
        .WA_in     (WA_in),
        .WB_in     (WB_in),
        .start     (start),
        .WA        (WA),
        .WB        (WB),
        .bitAout   (bitAout),
        .bitBout   (bitBout),
        .bsm_O     (bsm_O),
        .bsm_done  (bsm_done),
        .res       (res),
        .res_valid (res_valid),
        .res_err   (res_err),
        .res_ready (res_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sext(input logic [15:0] v, input int n);
        logic [31:0] r;
        r = {16'h0, v};
        for (int i = n; i < 32; i++) r[i] = v[n-1];
        return r;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, " start"}, start, 0);
        check({tag, " WA"}, WA, 0);
        check({tag, " WB"}, WB, 0);
        check({tag, " bitA"}, bitAout, 0);
        check({tag, " bitB"}, bitBout, 0);
        check({tag, " res"}, res, 0);
        check({tag, " res_valid"}, res_valid, 0);
        check({tag, " res_err"}, res_err, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " in_ready"}, in_ready, 1);
    endtask

    // Accept a pair, collect the serial bits, act as the multiplier (or stay
    // silent) and leave the block in RESULT with the result checked.
    task automatic run_op(input string tag,
                          input logic [31:0] a, input logic [4:0] wa,
                          input logic [31:0] b, input logic [4:0] wb,
                          input int nexp, input logic [15:0] exp_a, input logic [15:0] exp_b,
                          input logic [4:0] exp_wa, input logic [4:0] exp_wb,
                          input bit give_done, input logic [31:0] exp_res);
        logic [15:0] got_a;
        logic [15:0] got_b;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        in_valid = 1'b1;
        A_in = a; WA_in = wa;
        B_in = b; WB_in = wb;
        tick();
        in_valid = 1'b0;
        check({tag, " start pulse"}, start, 1);
        check({tag, " WA"}, WA, exp_wa);
        check({tag, " WB"}, WB, exp_wb);
        check({tag, " bitA in START"}, bitAout, 0);
        check({tag, " in_ready busy"}, in_ready, 0);
        tick();
        got_a = '0;
        got_b = '0;
        for (int i = 0; i < nexp; i++) begin
            if (start !== 1'b0) check({tag, " start single"}, start, 0);
            got_a[i] = bitAout;
            got_b[i] = bitBout;
            tick();
        end
        check({tag, " bitA serial"}, got_a, exp_a);
        check({tag, " bitB serial"}, got_b, exp_b);
        check({tag, " bitA in WAITD"}, bitAout, 0);
        check({tag, " WA held"}, WA, exp_wa);
        if (give_done) begin
            sa = sext(got_a, nexp);
            sb = sext(got_b, nexp);
            bsm_O = sa * sb;
            bsm_done = 1'b1;
            tick();
            bsm_done = 1'b0;
            bsm_O = 32'hDEAD_BEEF;
            check({tag, " res_valid"}, res_valid, 1);
            check({tag, " res_err"}, res_err, 0);
            check({tag, " res"}, res, exp_res);
        end else begin
            for (int i = 0; i < TIMEOUT; i++) begin
                if (res_valid !== 1'b0) check({tag, " early res_valid"}, res_valid, 0);
                tick();
            end
            check({tag, " tmo res_valid"}, res_valid, 1);
            check({tag, " tmo res_err"}, res_err, 1);
            check({tag, " tmo res"}, res, 0);
        end
    endtask

    // Hold off the consumer for 'hold' cycles while offering a new pair, then take the result.
    task automatic consume(input string tag, input int hold, input logic [31:0] exp_res, input logic exp_err);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            check({tag, " hold res"}, res, exp_res);
            check({tag, " hold res_valid"}, res_valid, 1);
            check({tag, " hold res_err"}, res_err, exp_err);
            check({tag, " hold in_ready"}, in_ready, 0);
            tick();
        end
        res_ready = 1'b1;
        check({tag, " take in_ready"}, in_ready, 0);
        tick();
        res_ready = 1'b0;
        check({tag, " cleared res_valid"}, res_valid, 0);
        check({tag, " cleared res_err"}, res_err, 0);
        check({tag, " idle in_ready"}, in_ready, 1);
        check({tag, " idle busy"}, busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        A_in = '0; B_in = '0; WA_in = '0; WB_in = '0;
        bsm_O = '0; bsm_done = 1'b0; res_ready = 1'b0;
        #1;
        check_reset_outputs("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();

        run_op("basic", 32'd5, 5'd4, 32'd3, 5'd3, 4, 16'h0005, 16'h0003, 5'd4, 5'd3, 1'b1, 32'd15);
        consume("bp", 10, 32'd15, 1'b0);

        run_op("signed", 32'hFFFF_FFFD, 5'd4, 32'd7, 5'd4, 4, 16'h000D, 16'h0007, 5'd4, 5'd4, 1'b1, 32'hFFFF_FFEB);
        consume("signed", 0, 32'hFFFF_FFEB, 1'b0);

        run_op("clamp", 32'd1, 5'd0, 32'd2, 5'd20, 16, 16'hFFFF, 16'h0002, 5'd1, 5'd16, 1'b1, 32'hFFFF_FFFE);
        consume("clamp", 1, 32'hFFFF_FFFE, 1'b0);

        run_op("timeout", 32'd5, 5'd4, 32'd3, 5'd3, 4, 16'h0005, 16'h0003, 5'd4, 5'd3, 1'b0, 32'd0);
        consume("timeout", 2, 32'd0, 1'b1);

        // Reset while the third bit is on the wire.
        in_valid = 1'b1;
        A_in = 32'hFFFF_FFFF; WA_in = 5'd8;
        B_in = 32'd5; WB_in = 5'd8;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("midrst bitA k2", bitAout, 1);
        check("midrst bitB k2", bitBout, 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bsm_done = (i == 3 || i == 12);
            bsm_O = 32'h1234_5678;
            if (res_valid !== 1'b0 || busy !== 1'b0) begin
                check("postrst res_valid", res_valid, 0);
                check("postrst busy", busy, 0);
            end
            tick();
        end
        bsm_done = 1'b0;
        check("postrst res_valid end", res_valid, 0);
        check("postrst res end", res, 0);
        check("postrst in_ready end", in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
